uart_pattern_loader: RTL and testbench
======================================

Name: uart_pattern_loader

Overview:
- UART 8N1 receiver on RXD that writes received LED pattern words into the pattern BRAM.
- Counterpart to the pattern player, which reads the BRAM and drives LEDS; this block is the write side, loading the animation at runtime.
- Sits in SOC on the divided internal clock, beside the player; drives the BRAM write port only.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (>= 4).
- DEPTH, 21, number of pattern words in the BRAM.
- ADDR_W, 5, write address width; 2**ADDR_W >= DEPTH.
- DATA_W, 5, pattern word width (<= 7).

Ports:
- clk  in  1  internal system clock.
- resetn  in  1  asynchronous, active-low reset.
- RXD  in  1  UART receive line, idle high, asynchronous to clk.
- wr_en  out  1  BRAM write strobe, one cycle.
- wr_addr  out  ADDR_W  BRAM write address.
- wr_data  out  DATA_W  BRAM write data.
- load_done  out  1  one-cycle pulse when word DEPTH-1 is written.
- frame_err  out  1  one-cycle pulse on a bad stop bit (or bad parity).

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; wr_en=0, wr_addr=0, wr_data=0, load_done=0, frame_err=0; bit counters 0; RXD synchroniser flops preset to 1.
- RXD passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- FSM states:
  - IDLE: rxs==0 -> START, baud counter cleared.
  - START: at count CLKS_PER_BIT/2 (integer divide), resample. rxs==0 -> DATA, counter cleared. rxs==1 -> IDLE (glitch rejected, no error).
  - DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first, shifted into byte register. After bit 7 -> STOP (or PARITY when the optional feature is enabled).
  - STOP: sample after CLKS_PER_BIT. rxs==1 -> byte valid, go to IDLE. rxs==0 -> frame_err pulse, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then IDLE. This prevents a break condition from retriggering reception.
- Byte decode, in the cycle after a valid stop-bit sample:
  - bit7==0: wr_en=1, wr_data=byte[DATA_W-1:0], wr_addr=current address. Address advances on the next cycle. If the address was DEPTH-1 it wraps to 0 and load_done pulses in the same cycle as wr_en.
  - byte==8'h80 (CMD_ADDR_RST): no write; address set to 0.
  - other bytes with bit7==1: ignored, no write, address unchanged.
- Latency: wr_en is asserted exactly 1 clk after the stop-bit sample cycle.
- wr_en, load_done and frame_err are never high for more than 1 cycle.
- wr_data and wr_addr hold their values between writes.
- Reset mid-frame: frame aborted, nothing written, address returns to 0.
- Back-to-back frames: a start bit may begin in the cycle after the stop sample; decode and write do not block reception.

Optional Feature:
- Macro: UART_LOADER_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state samples a 9th bit after DATA.
  - If the XOR of the 8 data bits plus the parity bit is 1, the byte is discarded and frame_err pulses at the stop-bit sample. The stop bit is still checked.
- Undefined: 8N1 only; the PARITY state and its logic are absent.

Decomposition:
- Package uart_loader_pkg holds:
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - CMD_ADDR_RST = 8'h80;
  - the helper constant HALF_BIT = CLKS_PER_BIT/2.
- Sub-module uart_rx_core contains the synchroniser, FSM, baud and bit counters, and parity check. Its outputs are byte[7:0], byte_valid (1 cycle) and frame_err.
- The top level handles byte decode and the address counter/wrap.

Test Plan (CLKS_PER_BIT=4, DEPTH=21):
- Reset, then send 0x15 -> wr_en pulses once; wr_addr=0, wr_data=5'b10101; frame_err stays 0.
- Send 21 bytes 0x00..0x14 back-to-back -> 21 writes at addresses 0..20, data equal to the low 5 bits; load_done pulses with the write to addr 20; the next byte 0x1F writes addr 0.
- Send 0x03, 0x07, then 0x80, then 0x1F -> writes at addr 0 and 1, then a write at addr 0 with 0x1F; 0x90 causes no write.
- RXD low for 1 clk only, then high -> no write, no frame_err, FSM returns to IDLE.
- Frame 0x0A with stop bit held 0 for 20 clks -> frame_err pulse, no write. Then send 0x0B after the line goes high -> write addr 0, data 5'b01011.
- resetn pulsed low mid-DATA of 0x11 -> outputs immediately 0, no write. Next full 0x11 -> write addr 0. With UART_LOADER_PARITY_EN, 0x11 with parity bit 1 -> frame_err pulse, no write.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART pattern loader.
//
// Contents:
//   rx_state_t   - receiver FSM state encoding
//   CMD_ADDR_RST - control byte that rewinds the write address to 0
//   half_bit()   - helper giving HALF_BIT = clks_per_bit / 2, the start-bit resample point
//
// Optional feature macro: UART_LOADER_PARITY_EN (8E1 framing; StParity is only
// reached when it is defined).
package uart_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } rx_state_t;

    localparam logic [7:0] CMD_ADDR_RST = 8'h80;

    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver core: RXD synchroniser, framing FSM, baud/bit counters and
// (optionally) even-parity check.
//
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   rxd        in   raw UART line, idle high, asynchronous to clk
//   rx_byte    out  assembled byte, LSB received first; stable while in StStop
//   byte_valid out  one-cycle strobe in the stop-bit sample cycle of a good frame
//   frame_err  out  one-cycle strobe in the stop-bit sample cycle of a bad frame
//
// byte_valid/frame_err are decoded from the registered state and counters so the
// top can register its write strobe exactly one clk after the stop-bit sample.
//
// Optional feature macro: UART_LOADER_PARITY_EN (adds StParity, 8E1 framing).
module uart_rx_core
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rxs;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             bit_tick;
    logic             stop_sample;
`ifdef UART_LOADER_PARITY_EN
    logic             par_err;
`endif

    // Preset to 1 so reset looks like an idle line, not a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    assign bit_tick    = (cnt == LAST_CNT);
    assign stop_sample = (state == StStop) && bit_tick;
    assign rx_byte     = shift;

`ifdef UART_LOADER_PARITY_EN
    assign byte_valid = stop_sample && rxs && !par_err;
    assign frame_err  = stop_sample && (!rxs || par_err);
`else
    assign byte_valid = stop_sample && rxs;
    assign frame_err  = stop_sample && !rxs;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= StIdle;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef UART_LOADER_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    cnt <= '0;
                    if (!rxs) state <= StStart;
                end
                StStart: begin
                    if (cnt == HALF_BIT) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        // A start bit that has gone high again was a glitch.
                        state   <= rxs ? StIdle : StData;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        shift   <= {rxs, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_LOADER_PARITY_EN
                StParity: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        par_err <= ^{rxs, shift};
                        state   <= StStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        // Low stop bit may be a break: wait for idle before re-arming.
                        state <= rxs ? StIdle : StWaitHigh;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (rxs) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_pattern_loader.sv
// UART pattern loader: receives bytes on RXD and writes LED pattern words into the
// pattern BRAM write port. Bytes with bit7=0 are data words written at a
// wrapping address; CMD_ADDR_RST rewinds the address; other bit7=1 bytes are ignored.
//
// Ports:
//   clk       in   system clock
//   resetn    in   asynchronous active-low reset
//   RXD       in   UART line, idle high
//   wr_en     out  BRAM write strobe (one cycle)
//   wr_addr   out  BRAM write address, held between writes
//   wr_data   out  BRAM write data, held between writes
//   load_done out  one-cycle pulse alongside the write to address DEPTH-1
//   frame_err out  one-cycle pulse on bad stop bit (or bad parity)
//
// Optional feature macro: UART_LOADER_PARITY_EN (8E1 framing in uart_rx_core).
module uart_pattern_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DEPTH        = 21,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              RXD,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              load_done,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              rx_frame_err;
    logic [ADDR_W-1:0] addr;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_core (
        .clk       (clk),
        .resetn    (resetn),
        .rxd       (RXD),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (rx_frame_err)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            load_done <= 1'b0;
            frame_err <= 1'b0;
            addr      <= '0;
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;
            frame_err <= rx_frame_err;
            if (byte_valid) begin
                if (!rx_byte[7]) begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    wr_data <= rx_byte[DATA_W-1:0];
                    if (addr == LAST_ADDR) begin
                        addr      <= '0;
                        load_done <= 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end else if (rx_byte == CMD_ADDR_RST) begin
                    addr <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_pattern_loader.sv
// Self-checking bench for uart_pattern_loader (CLKS_PER_BIT=4, DEPTH=21).
// A queue-based model predicts every BRAM write and frame error from the bytes sent.
module tb_uart_pattern_loader;

    localparam int CPB   = 4;
    localparam int DEPTH = 21;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       RXD = 1'b1;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [4:0] wr_data;
    logic       load_done;
    logic       frame_err;

    uart_pattern_loader #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH),
        .ADDR_W      (5),
        .DATA_W      (5)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .RXD      (RXD),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .load_done(load_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int ld;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  model_addr = 0;
    int  fe_exp = 0;
    int  fe_seen = 0;
    int  last_addr = 0;
    int  last_data = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: what the loader must do with one received frame.
    task automatic model_frame(input logic [7:0] b, input bit good);
        wr_t e;
        if (!good) begin
            fe_exp++;
        end else if (b[7] == 1'b0) begin
            e.addr = model_addr;
            e.data = int'(b[4:0]);
            e.ld   = (model_addr == DEPTH - 1) ? 1 : 0;
            exp_q.push_back(e);
            model_addr = (model_addr == DEPTH - 1) ? 0 : model_addr + 1;
        end else if (b == 8'h80) begin
            model_addr = 0;
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_val, input int stop_clks,
                              input bit bad_par);
        RXD = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            wait_clks(CPB);
        end
`ifdef UART_LOADER_PARITY_EN
        RXD = (^b) ^ bad_par;
        wait_clks(CPB);
`endif
        RXD = stop_val;
        wait_clks(stop_clks);
        RXD = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        model_frame(b, 1'b1);
        send_frame(b, 1'b1, CPB, 1'b0);
    endtask

    task automatic settle();
        wait_clks(8 * CPB);
        check_eq("pending_writes", exp_q.size(), 0);
        check_eq("frame_err_count", fe_seen, fe_exp);
        check_eq("wr_addr_hold", {27'd0, wr_addr}, last_addr);
        check_eq("wr_data_hold", {27'd0, wr_data}, last_data);
    endtask

    // Output monitor, sampling on the falling edge.
    logic prev_wr = 1'b0;
    logic prev_ld = 1'b0;
    logic prev_fe = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            prev_wr = 1'b0;
            prev_ld = 1'b0;
            prev_fe = 1'b0;
        end else begin
            if (prev_wr) check_eq("wr_en_one_cycle", wr_en, 0);
            if (prev_ld) check_eq("load_done_one_cycle", load_done, 0);
            if (prev_fe) check_eq("frame_err_one_cycle", frame_err, 0);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check_eq("wr_addr", {27'd0, wr_addr}, e.addr);
                    check_eq("wr_data", {27'd0, wr_data}, e.data);
                    check_eq("load_done", {31'd0, load_done}, e.ld);
                    last_addr = e.addr;
                    last_data = e.data;
                end
            end else if (load_done) begin
                check_eq("load_done_without_write", load_done, 0);
            end
            if (frame_err) fe_seen++;
            prev_wr = wr_en;
            prev_ld = load_done;
            prev_fe = frame_err;
        end
    end

    initial begin
        logic [7:0] b;
        int r;

        // Reset state
        wait_clks(3);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_addr", {27'd0, wr_addr}, 0);
        check_eq("rst_wr_data", {27'd0, wr_data}, 0);
        check_eq("rst_load_done", load_done, 0);
        check_eq("rst_frame_err", frame_err, 0);
        resetn = 1'b1;
        wait_clks(4);

        // Single byte
        send_good(8'h15);
        settle();

        // Full load with wrap, back-to-back frames
        send_good(8'h80);
        for (int i = 0; i <= 20; i++) send_good(8'(i));
        send_good(8'h1F);
        settle();

        // Address-reset command and ignored command
        send_good(8'h03);
        send_good(8'h07);
        send_good(8'h80);
        send_good(8'h1F);
        send_good(8'h90);
        settle();

        // One-clock glitch on an idle line
        RXD = 1'b0;
        wait_clks(1);
        RXD = 1'b1;
        settle();

        // Break-like stop bit, then a normal frame
        model_frame(8'h0A, 1'b0);
        send_frame(8'h0A, 1'b0, 20, 1'b0);
        wait_clks(2);
        send_good(8'h0B);
        settle();

        // Reset in the middle of the data bits
        RXD = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 3; i++) begin
            RXD = (i == 0) ? 1'b1 : 1'b0;
            wait_clks(CPB);
        end
        resetn = 1'b0;
        #1;
        check_eq("midrst_wr_en", wr_en, 0);
        check_eq("midrst_wr_addr", {27'd0, wr_addr}, 0);
        check_eq("midrst_wr_data", {27'd0, wr_data}, 0);
        check_eq("midrst_frame_err", frame_err, 0);
        model_addr = 0;
        last_addr = 0;
        last_data = 0;
        RXD = 1'b1;
        wait_clks(3);
        resetn = 1'b1;
        wait_clks(3);
        send_good(8'h11);
        settle();

`ifdef UART_LOADER_PARITY_EN
        model_frame(8'h11, 1'b0);
        send_frame(8'h11, 1'b1, CPB, 1'b1);
        settle();
`endif

        // Randomized traffic with random gaps
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) b = 8'($urandom) & 8'h7F;
            else if (r < 8) b = 8'h80;
            else b = 8'h80 | 8'($urandom_range(1, 127));
            send_good(b);
            wait_clks($urandom_range(0, 3));
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
